mem_port_arbiter: RTL and testbench

//   Shares one single-ported instruction/data RAM between the IF stage (instruction fetch)
//   and the MEM stage (load/store) of the 5-stage pipeline CPU.

---
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF and MEM pipeline stages onto one single-ported RAM and sequences each access.
// Optional IF starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic          mem_gnt,
  output logic          mem_done,
  output logic [DW-1:0] mem_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAP} state_t;

  state_t        state;
  logic          owner_mem;
  logic          we_q;
  logic [CW-1:0] cnt;
  logic          grant_mem;

  if (MEM_LAT < 1) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be >= 1");
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;

  // Once MEM has won STARVE_MAX times in a row over a waiting IF, IF takes the next slot.
  assign grant_mem = mem_req && (starve_cnt != SW'(STARVE_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!if_req) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      starve_cnt <= grant_mem ? starve_cnt + 1'b1 : '0;
    end
  end
`else
  assign grant_mem = mem_req;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the rdata holding registers are reset too, so an abandoned access leaves no stale data.
    if (rst) begin
      state     <= IDLE;
      owner_mem <= 1'b0;
      we_q      <= 1'b0;
      cnt       <= '0;
      if_gnt    <= 1'b0;
      if_done   <= 1'b0;
      if_rdata  <= '0;
      mem_gnt   <= 1'b0;
      mem_done  <= 1'b0;
      mem_rdata <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      // NOTE: pulses default low with non-blocking updates; a state below raises them for one cycle.
      if_gnt   <= 1'b0;
      mem_gnt  <= 1'b0;
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_mem) begin
            state     <= ISSUE;
            owner_mem <= 1'b1;
            we_q      <= mem_we;
            mem_gnt   <= 1'b1;
            ram_en    <= 1'b1;
            ram_we    <= mem_we;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
          end else if (if_req) begin
            state     <= ISSUE;
            owner_mem <= 1'b0;
            we_q      <= 1'b0;
            if_gnt    <= 1'b1;
            ram_en    <= 1'b1;
            ram_addr  <= if_addr;
            ram_wdata <= '0;
          end
        end
        ISSUE: begin
          if (MEM_LAT > 1) begin
            state <= WAIT;
            cnt   <= CW'(MEM_LAT - 1);
          end else begin
            state <= CAP;
          end
        end
        WAIT: begin
          if (cnt <= CW'(1)) begin
            cnt   <= '0;
            state <= CAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CAP: begin
          state <= IDLE;
          if (owner_mem) begin
            if (!we_q) mem_rdata <= ram_rdata;
            mem_done <= 1'b1;
          end else begin
            if_rdata <= ram_rdata;
            if_done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=2 instance and a MEM_LAT=1 instance behind a latency-exact RAM model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // MEM_LAT=2 instance
  logic        if_req, if_gnt, if_done, mem_req, mem_we, mem_gnt, mem_done;
  logic        ram_en, ram_we, busy;
  logic [31:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;

  // MEM_LAT=1 instance
  logic        if_req1, if_gnt1, if_done1, mem_req1, mem_we1, mem_gnt1, mem_done1;
  logic        ram_en1, ram_we1, busy1;
  logic [31:0] if_addr1, if_rdata1, mem_addr1, mem_wdata1, mem_rdata1, ram_addr1, ram_wdata1, ram_rdata1;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1), .if_done(if_done1), .if_rdata(if_rdata1),
    .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_gnt(mem_gnt1), .mem_done(mem_done1), .mem_rdata(mem_rdata1),
    .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
    .ram_rdata(ram_rdata1), .busy(busy1)
  );

  // Read-only RAM contents; data is presented only in the exact cycle it becomes valid.
  function automatic logic [31:0] ram_model(input logic [31:0] a);
    case (a)
      32'h10:  return 32'hDEADBEEF;
      32'h14:  return 32'hCAFEF00D;
      32'h18:  return 32'h01234567;
      32'h40:  return 32'h12345678;
      default: return 32'h0;
    endcase
  endfunction

  localparam logic [31:0] JUNK = 32'hBAD0BAD0;

  logic [31:0] pd [2];
  logic        pv [2];
  logic [31:0] pd1;
  logic        pv1;

  always @(posedge clk) begin
    if (rst) begin
      pv[0] <= 1'b0;
      pv[1] <= 1'b0;
      pv1   <= 1'b0;
    end else begin
      pd[0] <= ram_model(ram_addr);
      pv[0] <= ram_en && !ram_we;
      pd[1] <= pd[0];
      pv[1] <= pv[0];
      pd1   <= ram_model(ram_addr1);
      pv1   <= ram_en1 && !ram_we1;
    end
  end

  assign ram_rdata  = pv[1] ? pd[1] : JUNK;
  assign ram_rdata1 = pv1 ? pd1 : JUNK;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".if_gnt"},    32'(if_gnt),   32'h0);
    check({tag, ".if_done"},   32'(if_done),  32'h0);
    check({tag, ".if_rdata"},  if_rdata,      32'h0);
    check({tag, ".mem_gnt"},   32'(mem_gnt),  32'h0);
    check({tag, ".mem_done"},  32'(mem_done), 32'h0);
    check({tag, ".mem_rdata"}, mem_rdata,     32'h0);
    check({tag, ".ram_en"},    32'(ram_en),   32'h0);
    check({tag, ".ram_we"},    32'(ram_we),   32'h0);
    check({tag, ".ram_addr"},  ram_addr,      32'h0);
    check({tag, ".ram_wdata"}, ram_wdata,     32'h0);
    check({tag, ".busy"},      32'(busy),     32'h0);
  endtask

  int n_mem, n_if, n_en, both, first_if, mem_before, stray;

  initial begin
    rst = 1'b1;
    {if_req, mem_req, mem_we} = '0;
    {if_addr, mem_addr, mem_wdata} = '0;
    {if_req1, mem_req1, mem_we1} = '0;
    {if_addr1, mem_addr1, mem_wdata1} = '0;
    #2;
    check_all_zero("reset");
    check("reset.busy1", 32'(busy1), 32'h0);
    repeat (2) step();
    rst = 1'b0;
    step();

    // 1: IF fetch, MEM_LAT=2
    if_req = 1'b1; if_addr = 32'h10;
    step();  // c1
    check("t1.if_gnt", 32'(if_gnt), 32'h1);
    check("t1.ram_en", 32'(ram_en), 32'h1);
    check("t1.ram_we", 32'(ram_we), 32'h0);
    check("t1.ram_addr", ram_addr, 32'h10);
    check("t1.ram_wdata", ram_wdata, 32'h0);
    check("t1.busy", 32'(busy), 32'h1);
    if_req = 1'b0;
    step();  // c2
    check("t1.c2_gnt", 32'(if_gnt), 32'h0);
    check("t1.c2_ram_en", 32'(ram_en), 32'h0);
    step();  // c3
    check("t1.c3_done", 32'(if_done), 32'h0);
    step();  // c4
    check("t1.if_done", 32'(if_done), 32'h1);
    check("t1.if_rdata", if_rdata, 32'hDEADBEEF);
    check("t1.busy_idle", 32'(busy), 32'h0);
    step();
    check("t1.done_pulse", 32'(if_done), 32'h0);

    // 2: simultaneous requests, MEM wins
    if_req = 1'b1; if_addr = 32'h14;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40;
    step();  // c1
    check("t2.mem_gnt", 32'(mem_gnt), 32'h1);
    check("t2.if_gnt_c1", 32'(if_gnt), 32'h0);
    check("t2.ram_addr", ram_addr, 32'h40);
    mem_req = 1'b0;
    repeat (3) step();  // c4
    check("t2.mem_done", 32'(mem_done), 32'h1);
    check("t2.mem_rdata", mem_rdata, 32'h12345678);
    check("t2.if_gnt_c4", 32'(if_gnt), 32'h0);
    step();  // c5
    check("t2.if_gnt_c5", 32'(if_gnt), 32'h1);
    check("t2.ram_addr_if", ram_addr, 32'h14);
    if_req = 1'b0;
    repeat (3) step();  // c8
    check("t2.if_done", 32'(if_done), 32'h1);
    check("t2.if_rdata", if_rdata, 32'hCAFEF00D);
    step();

    // 3: store
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h20; mem_wdata = 32'h5;
    step();  // c1
    check("t3.ram_en", 32'(ram_en), 32'h1);
    check("t3.ram_we", 32'(ram_we), 32'h1);
    check("t3.ram_addr", ram_addr, 32'h20);
    check("t3.ram_wdata", ram_wdata, 32'h5);
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    step();  // c2
    check("t3.ram_we_c2", 32'(ram_we), 32'h0);
    check("t3.ram_wdata_held", ram_wdata, 32'h5);
    repeat (2) step();  // c4
    check("t3.mem_done", 32'(mem_done), 32'h1);
    check("t3.mem_rdata", mem_rdata, 32'h12345678);
    step();

    // 4: reset mid-WAIT
    if_req = 1'b1; if_addr = 32'h10;
    step();  // c1
    if_req = 1'b0;
    step();  // c2 (WAIT)
    rst = 1'b1;
    #1;
    check_all_zero("t4");
    repeat (2) step();
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      stray += int'(if_done) + int'(mem_done) + int'(ram_en);
    end
    check("t4.no_stray", 32'(stray), 32'h0);
    if_req = 1'b1; if_addr = 32'h14;
    step();
    check("t4.regnt", 32'(if_gnt), 32'h1);
    if_req = 1'b0;
    repeat (3) step();
    check("t4.redone", 32'(if_done), 32'h1);
    check("t4.rdata", if_rdata, 32'hCAFEF00D);
    step();

    // 5: MEM_LAT=1 back-to-back fetches; second request raised in CAP is ignored until IDLE
    if_req1 = 1'b1; if_addr1 = 32'h10;
    step();  // c1
    check("t5.gnt_c1", 32'(if_gnt1), 32'h1);
    if_req1 = 1'b0;
    step();  // c2 (CAP)
    check("t5.done_c2", 32'(if_done1), 32'h0);
    if_req1 = 1'b1; if_addr1 = 32'h18;
    step();  // c3
    check("t5.done_c3", 32'(if_done1), 32'h1);
    check("t5.rdata1", if_rdata1, 32'hDEADBEEF);
    check("t5.gnt_c3", 32'(if_gnt1), 32'h0);
    step();  // c4
    check("t5.gnt_c4", 32'(if_gnt1), 32'h1);
    check("t5.addr_c4", ram_addr1, 32'h18);
    if_req1 = 1'b0;
    step();  // c5
    check("t5.done_c5", 32'(if_done1), 32'h0);
    step();  // c6
    check("t5.done_c6", 32'(if_done1), 32'h1);
    check("t5.rdata2", if_rdata1, 32'h01234567);
    step();

    // 6: both requests held for 40 cycles
    if_req = 1'b1; if_addr = 32'h18;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40;
    n_mem = 0; n_if = 0; n_en = 0; both = 0; first_if = 0; mem_before = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (if_gnt && first_if == 0) begin
        first_if   = i;
        mem_before = n_mem;
      end
      n_mem += int'(mem_gnt);
      n_if  += int'(if_gnt);
      n_en  += int'(ram_en);
      if (if_gnt && mem_gnt) both++;
    end
    if_req = 1'b0; mem_req = 1'b0;
    check("t6.one_gnt", 32'(both), 32'h0);
    check("t6.ram_en_count", 32'(n_en), 32'(n_mem + n_if));
`ifdef ARB_STARVE_GUARD_EN
    check("t6.first_if_cycle", 32'(first_if), 32'd17);
    check("t6.mem_before_if", 32'(mem_before), 32'd4);
    check("t6.mem_gnts", 32'(n_mem), 32'd8);
    check("t6.if_gnts", 32'(n_if), 32'd2);
`else
    check("t6.if_gnts", 32'(n_if), 32'd0);
    check("t6.mem_gnts", 32'(n_mem), 32'd10);
`endif
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
